// File: rtl/dmem_pkg.sv
// Shared types and default constants for the data-memory responder and its max monitor.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int unsigned DEF_ADDR_W      = 10;
    localparam int unsigned DEF_WAIT_CYCLES = 2;
    localparam int unsigned DEF_SCAN_BASE   = 1000;
    localparam int unsigned DEF_SCAN_LEN    = 20;

    localparam logic [31:0] MAX_RESET = 32'h8000_0000;

endpackage

// File: rtl/data_mem_responder_max_tracker.sv
// High-water signed maximum over a fixed word window, updated on each committed write.
module max_tracker
    import dmem_pkg::*;
#(
    parameter int unsigned SCAN_BASE = DEF_SCAN_BASE,
    parameter int unsigned SCAN_LEN  = DEF_SCAN_LEN
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_commit,
    input  logic [29:0] i_addr_word,
    input  logic [31:0] i_data,
    output logic [31:0] o_max,
    output logic [31:0] o_max_index
);

    localparam logic [31:0] LP_BASE = SCAN_BASE[31:0];
    localparam logic [31:0] LP_END  = LP_BASE + 32'(4 * SCAN_LEN);

    logic [31:0] r_max;
    logic [31:0] r_max_index;
    logic [31:0] w_addr;
    logic [31:0] w_index;
    logic        w_in_window;
    logic        w_greater;

    assign w_addr      = {i_addr_word, 2'b00};
    assign w_in_window = (w_addr >= LP_BASE) && (w_addr < LP_END);
    assign w_index     = (w_addr - LP_BASE) >> 2;
    // Strict compare so a tie keeps the earlier index.
    assign w_greater   = $signed(i_data) > $signed(r_max);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_max       <= MAX_RESET;
            r_max_index <= '0;
        end else if (i_commit && w_in_window && w_greater) begin
            r_max       <= i_data;
            r_max_index <= w_index;
        end
    end

    assign o_max       = r_max;
    assign o_max_index = r_max_index;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder with programmable wait states and a windowed max monitor.
// Optional read/write completion counters are enabled with DMEM_STATS_EN.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int unsigned SCAN_BASE   = DEF_SCAN_BASE,
    parameter int unsigned SCAN_LEN    = DEF_SCAN_LEN
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [31:0] i_address,
    input  logic [31:0] i_write_data,
    output logic [31:0] o_read_data,
    output logic        o_ready,
    output logic [31:0] o_max,
    output logic [31:0] o_max_index
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0] o_read_count,
    output logic [15:0] o_write_count
`endif
);

    localparam int unsigned DEPTH   = 2 ** ADDR_W;
    localparam logic [3:0]  LP_WAIT = 4'(WAIT_CYCLES);

    state_t             r_state;
    state_t             w_state_next;
    logic [3:0]         r_count;
    logic [3:0]         w_count_next;
    logic               r_op_write;
    logic [29:0]        r_addr_hi;
    logic [31:0]        r_wdata;
    logic [31:0]        r_read_data;
    logic               r_ready;
    logic [31:0]        r_mem [DEPTH];

    logic               w_req;
    logic               w_capture;
    logic               w_op_write_next;
    logic [ADDR_W-1:0]  w_rd_index;
    logic               w_commit;
    logic               w_unused;

    assign w_req     = i_mem_read | i_mem_write;
    assign w_capture = (r_state == IDLE) && w_req;
    assign w_unused  = ^i_address[1:0];

    // Write wins when both requests are high.
    assign w_op_write_next = (r_state == IDLE) ? i_mem_write : r_op_write;
    // With zero wait states the read lands on the capture edge, so index from the live address.
    assign w_rd_index = (r_state == IDLE) ? i_address[ADDR_W+1:2] : r_addr_hi[ADDR_W-1:0];
    assign w_commit   = (r_state == RESP) && r_op_write;

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_count_next = LP_WAIT;
                    w_state_next = (LP_WAIT == 4'd0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                w_count_next = r_count - 4'd1;
                if (r_count <= 4'd1) begin
                    w_state_next = RESP;
                end
            end
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_op_write  <= 1'b0;
            r_addr_hi   <= '0;
            r_wdata     <= '0;
            r_read_data <= '0;
            r_ready     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_ready <= (w_state_next == RESP);
            if (w_capture) begin
                r_op_write <= i_mem_write;
                r_addr_hi  <= i_address[31:2];
                r_wdata    <= i_write_data;
            end
            if ((w_state_next == RESP) && !w_op_write_next) begin
                r_read_data <= r_mem[w_rd_index];
            end
        end
    end

    // Array is deliberately not reset; an aborted transaction never reaches RESP.
    always_ff @(posedge i_clk) begin
        if (w_commit) begin
            r_mem[r_addr_hi[ADDR_W-1:0]] <= r_wdata;
        end
    end

    max_tracker #(
        .SCAN_BASE (SCAN_BASE),
        .SCAN_LEN  (SCAN_LEN)
    ) u_max_tracker (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_commit    (w_commit),
        .i_addr_word (r_addr_hi),
        .i_data      (r_wdata),
        .o_max       (o_max),
        .o_max_index (o_max_index)
    );

`ifdef DMEM_STATS_EN
    logic [15:0] r_read_count;
    logic [15:0] r_write_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_read_count  <= '0;
            r_write_count <= '0;
        end else if (r_state == RESP) begin
            if (r_op_write) begin
                if (r_write_count != 16'hFFFF) begin
                    r_write_count <= r_write_count + 16'd1;
                end
            end else if (r_read_count != 16'hFFFF) begin
                r_read_count <= r_read_count + 16'd1;
            end
        end
    end

    assign o_read_count  = r_read_count;
    assign o_write_count = r_write_count;
`endif

    assign o_read_data = r_read_data;
    assign o_ready     = r_ready;

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the MIPS data-memory interface: accepts read/write requests from the processor and returns data with a ready handshake after a programmable number of wait states.
- Targets the multicycle/stalling core variants; the single-cycle core sees it with WAIT_CYCLES=0.
- Also maintains a running max/maxIndex monitor over a fixed array window, replacing the testbench-side max reporting.

Parameters:
- ADDR_W, 10, word-index width; memory depth = 2**ADDR_W words of 32 bits.
- WAIT_CYCLES, 2, wait states between request capture and response (0..15).
- SCAN_BASE, 1000, byte address of array element 0 for the max monitor (word aligned).
- SCAN_LEN, 20, number of words in the monitored window.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- memRead  input  1  read request, held by requester until ready.
- memWrite  input  1  write request, held by requester until ready.
- address  input  32  byte address; bits [1:0] ignored.
- writeData  input  32  write data.
- readData  output  32  read data, valid while ready=1 for a read.
- ready  output  1  one-cycle completion pulse.
- max  output  32  largest signed value written into the window.
- maxIndex  output  32  element index (0..SCAN_LEN-1) of max.

Behaviour:
- Reset (rst=0, async): state=IDLE; ready=0; readData=0; max=32'h8000_0000; maxIndex=0; wait counter=0. Memory array is not cleared.
- Word index = address[ADDR_W+1:2]. Higher address bits are ignored, so addresses wrap modulo the depth.
- FSM IDLE/WAIT/RESP:
  - IDLE: when memRead|memWrite, latch op, index and writeData; load counter=WAIT_CYCLES. Go to WAIT, or to RESP directly if WAIT_CYCLES=0.
  - WAIT: decrement the counter each cycle; go to RESP when the counter is 1.
  - RESP: ready=1 for exactly one cycle. A write is committed to the array at the RESP clock edge. For a read, readData = mem[latched index], registered and held until the next read's RESP. Return to IDLE.
- Latency: ready is asserted WAIT_CYCLES+1 cycles after the request is first sampled in IDLE.
- Back-to-back: a request still asserted in the cycle after RESP is treated as a new request; requesters must deassert on seeing ready.
- memRead and memWrite both high: treated as a write only; readData is unchanged.
- Request inputs are sampled only in IDLE; changes during WAIT/RESP are ignored.
- Max monitor, evaluated on each committed write:
  - Applies only if SCAN_BASE <= {address[31:2],2'b00} < SCAN_BASE+4*SCAN_LEN.
  - If signed writeData > max: max=writeData and maxIndex=(addr-SCAN_BASE)>>2.
  - Ties keep the earlier index.
  - High-water semantics: overwriting the max location with a smaller value does not lower max.
- Reset mid-transaction: the pending operation is abandoned, no write is committed, and the FSM returns to IDLE.

Optional Feature:
- Macro DMEM_STATS_EN.
- Defined: adds outputs readCount[15:0] and writeCount[15:0]. Each counts completed RESP cycles of its type, saturates at 16'hFFFF, and resets to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package dmem_pkg: state enum (IDLE, WAIT, RESP), default ADDR_W/WAIT_CYCLES/SCAN_BASE/SCAN_LEN constants, and the MAX_RESET value 32'h8000_0000.
- One sub-module, max_tracker. Inputs: write-commit strobe, address, data. Outputs: registered max and maxIndex. Holds the window compare and the signed compare.

Test Plan:
- Reset, then a write of 32'd77 to addr 40 and a read of addr 40 (WAIT_CYCLES=2) -> ready pulses 3 cycles after each request; readData=77 during the read's ready cycle.
- WAIT_CYCLES=0, back-to-back reads of addr 0 and addr 4 -> ready one cycle after each capture; readData follows the stored values.
- Writes of 5, -3, 12, 12, 9 to SCAN_BASE+0,+4,+8,+12,+16 -> max=12, maxIndex=2 (tie keeps earlier index).
- Write 100 to SCAN_BASE-4 and write 200 to SCAN_BASE+80 (outside the window, SCAN_LEN=20) -> max/maxIndex unchanged.
- memRead=memWrite=1, address 8, data 32'hDEAD_BEEF -> the write is committed, readData is unchanged; a later read of addr 8 returns DEADBEEF.
- Assert rst low during WAIT of a write to addr 12 -> ready stays 0, mem[3] is unchanged, max resets to 32'h8000_0000; with DMEM_STATS_EN, the counters read 0.
